// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and sends it as an
// async-serial frame (start 0, data LSB first, stop 1) on a registered, idle-high line.
module serial_tx_shifter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              tx_serial_o,
  output logic              tx_busy_o,
  output logic              tx_done_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_W) + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BaudLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_valid_i) begin
          state_d = StStart;
          shift_d = tx_data_i;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The line level is computed from the next state so the registered pin lines up with
  // the state register: start bit appears the cycle after accept.
  always_comb begin
    tx_ready_o = (state_q == StIdle);
    tx_busy_o  = (state_q != StIdle);
    unique case (state_d)
      StStart: serial_d = 1'b0;
      StData:  serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  assign tx_serial_o = serial_q;
  assign tx_done_o   = done_q;

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-to-serial transmitter: the output-side counterpart of the team's edge-triggered capture elements.
- Accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single registered line as an asynchronous-serial frame: start bit 0, data LSB first, stop bit 1.
- Sits between a parallel producer (counter, FSM, switch bank) and a board-level serial pin.
- All state is rising-edge flip-flops. No latches, no negedge logic.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 4, clk cycles each bit is held on the line (>=1).

Ports:
- clk  input  1  single system clock; all flops update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  DATA_W  word to send; sampled only at accept.
- tx_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line, registered; idles high.
- tx_busy  output  1  frame in progress (not IDLE).
- tx_done  output  1  one-cycle pulse after stop bit completes.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0, immediately (no clock needed): state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0; bit and baud counters and shift register cleared.
- States: IDLE, START, DATA, STOP.
- Outputs by state:
  - tx_ready=1 only in IDLE.
  - tx_busy = (state != IDLE).
- Accept:
  - Occurs on a rising edge with state=IDLE and tx_valid=1.
  - tx_data is latched into the shift register and state becomes START.
  - tx_valid=0 in IDLE means stay in IDLE, tx_serial=1.
- START:
  - tx_serial=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Bit k (k=0..DATA_W-1, LSB first) is driven for CLKS_PER_BIT cycles each.
  - Shift register shifts right at each bit boundary.
  - After bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_done:
  - High for exactly the first IDLE cycle after STOP; 0 otherwise.
- Latency and frame length:
  - tx_serial is a registered output, so the start bit appears on the cycle after accept.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
- Back-to-back:
  - tx_ready=1 during the tx_done cycle.
  - If tx_valid=1 then, the next word is accepted in that cycle, giving exactly one idle-high cycle between frames.
- Input stability:
  - Changes to tx_data or tx_valid while busy are ignored.
  - The word in flight is unaffected.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter is sized ceil(log2(DATA_W))+1 bits; no overflow is permitted.
  - With CLKS_PER_BIT=1, each bit lasts one cycle.
- Reset mid-frame:
  - Frame is aborted and the line goes high immediately.
  - After release, the block is in IDLE and no tx_done is produced for the aborted frame.
- No glitches: tx_serial changes only at clk rising edges, except on async reset assertion.

Test Plan:
- Reset: hold rst_n=0 with tx_valid=1 and clock running -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; release -> still idle until tx_valid is sampled.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, send 0xA5 -> line holds 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), 4 cycles each, 40 cycles total; tx_done high one cycle at cycle 41; tx_busy high for exactly 40 cycles.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> frames separated by exactly one idle-high cycle; second frame's data bits are all 1s.
- Input change while busy: accept 0x3C, then change tx_data to 0xC3 mid-frame -> transmitted bits still 0,0,1,1,1,1,0,0; tx_ready=0 for the whole frame.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx_serial=1 immediately (before the next edge); after release, no tx_done; the next accepted word 0x81 transmits correctly.
- Parameter corner: CLKS_PER_BIT=1, DATA_W=4, send 0x9 -> serial 0,1,0,0,1,1 on consecutive cycles, tx_done on the following cycle.
